key_input_bank: RTL and testbench

- Multi-channel key front end: 2-flop synchroniser, per-key debounce, and event detection for press, release, long-press and auto-repeat.
- Generalises the single-key debouncer to NUM_KEYS channels running on the system clock. Sampling is gated by a strobe from the clock generator (e.g. the 100 Hz tick), so there is no derived clock.
- Sits between the board buttons/keyboard and the game controller (gomoku_main). Consumers get clean one-cycle event pulses instead of levels.

---
 rtl/gomoku_key_pkg.sv | 31 +++
 rtl/key_input_bank_chan.sv | 146 ++++++++++++++
 rtl/key_input_bank.sv | 57 +++++
 tb/tb_key_input_bank.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gomoku_key_pkg.sv
// gomoku_key_pkg: shared types and defaults for the key front end.
// Provides the channel-state enum, tick defaults and level helpers.
package gomoku_key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DEB,
    ST_HELD,
    ST_LONG,
    ST_REL_DEB
  } chan_state_t;

  localparam int DEF_DEB_TICKS    = 4;
  localparam int DEF_LONG_TICKS   = 100;
  localparam int DEF_REPEAT_TICKS = 20;
  localparam int DEF_CNT_W        = 8;

  // Raw input level seen while the key is not pressed.
  function automatic logic released_level(input bit active_low);
    return active_low;
  endfunction

  function automatic int max_tick(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_input_bank_chan.sv
// key_input_chan: one key channel (2-flop sync, debounce FSM, events).
// Ports: clk, rst_n, sample_en, key_raw in; key_level and pulses out.
module key_input_chan
  import gomoku_key_pkg::*;
#(
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEB_TICKS    = DEF_DEB_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam logic REL_LVL = released_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_T = CNT_W'(DEB_TICKS);
  localparam logic [CNT_W-1:0] LNG_T = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] REP_T = CNT_W'(REPEAT_TICKS);

  logic        s1, s2, p;
  chan_state_t state;
  logic        long_flag;
  logic [CNT_W-1:0] cnt, hold_cnt, rep_cnt;
  logic [CNT_W-1:0] cnt_nx, hold_nx, rep_nx;

  assign p       = ACTIVE_LOW ? ~s2 : s2;
  assign cnt_nx  = cnt + ONE;
  assign hold_nx = hold_cnt + ONE;
  assign rep_nx  = rep_cnt + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= REL_LVL;
      s2 <= REL_LVL;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      long_flag   <= 1'b0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
      if (sample_en) begin
        unique case (state)
          ST_IDLE: begin
            if (p) begin
              if (DEB_TICKS == 1) begin
                state     <= ST_HELD;
                hold_cnt  <= '0;
                key_press <= 1'b1;
                key_level <= 1'b1;
              end else begin
                state <= ST_PRESS_DEB;
                cnt   <= ONE;
              end
            end
          end
          ST_PRESS_DEB: begin
            if (!p) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (cnt_nx == DEB_T) begin
              state     <= ST_HELD;
              cnt       <= '0;
              hold_cnt  <= '0;
              key_press <= 1'b1;
              key_level <= 1'b1;
            end else begin
              cnt <= cnt_nx;
            end
          end
          ST_HELD, ST_LONG: begin
            if (!p) begin
              // A one-sample debounce accepts the release immediately.
              if (DEB_TICKS == 1) begin
                state       <= ST_IDLE;
                key_release <= 1'b1;
                key_level   <= 1'b0;
                long_flag   <= 1'b0;
              end else begin
                state <= ST_REL_DEB;
                cnt   <= ONE;
              end
            end else if (state == ST_HELD) begin
              hold_cnt <= hold_nx;
              if (hold_nx == LNG_T) begin
                state     <= ST_LONG;
                long_flag <= 1'b1;
                key_long  <= 1'b1;
                rep_cnt   <= '0;
              end
            end else if (REPEAT_TICKS != 0) begin
              if (rep_nx == REP_T) begin
                rep_cnt    <= '0;
                key_repeat <= 1'b1;
              end else begin
                rep_cnt <= rep_nx;
              end
            end
          end
          ST_REL_DEB: begin
            // A glitch resumes the hold; hold/repeat counts stay frozen.
            if (p) begin
              state <= long_flag ? ST_LONG : ST_HELD;
              cnt   <= '0;
            end else if (cnt_nx == DEB_T) begin
              state       <= ST_IDLE;
              cnt         <= '0;
              key_release <= 1'b1;
              key_level   <= 1'b0;
              long_flag   <= 1'b0;
            end else begin
              cnt <= cnt_nx;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/key_input_bank.sv
// key_input_bank: NUM_KEYS debounced key channels with event pulses.
// Ports: clk, rst_n, sample_en, key_raw[N] in; level/press/release/long/repeat[N] out.
module key_input_bank
  import gomoku_key_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEB_TICKS    = DEF_DEB_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);

  localparam int MAX_TICK =
    max_tick(DEB_TICKS, LONG_TICKS, REPEAT_TICKS);

  if (DEB_TICKS < 1) begin : g_bad_deb
    $error("DEB_TICKS must be >= 1");
  end
  if (LONG_TICKS <= DEB_TICKS) begin : g_bad_long
    $error("LONG_TICKS must exceed DEB_TICKS");
  end
  if ((MAX_TICK >> CNT_W) != 0) begin : g_bad_w
    $error("CNT_W too narrow for tick counts");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_input_chan #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .DEB_TICKS   (DEB_TICKS),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_en  (sample_en),
      .key_raw    (key_raw[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i]),
      .key_repeat (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_input_bank.sv
// tb_key_input_bank: table vectors plus event scoreboard for key_input_bank.
// Events are expected at absolute strobe numbers and matched as they pulse.
module tb_key_input_bank;

  logic       clk, rst_n, sample_en;
  logic [3:0] key_raw, key_level;
  logic [3:0] key_press, key_release, key_long, key_repeat;

  key_input_bank #(
    .NUM_KEYS(4), .ACTIVE_LOW(1'b1), .DEB_TICKS(4),
    .LONG_TICKS(10), .REPEAT_TICKS(3), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
    .key_raw(key_raw), .key_level(key_level),
    .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat)
  );

  typedef struct {
    int s;
    int ch;
    int kind;
  } ev_t;

  typedef struct {
    logic [3:0] raw;
    int         n;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lvl;
  } vec_t;

  ev_t  sb[$];
  vec_t tbl[9];
  int   checks = 0;
  int   errors = 0;
  int   scnt = 0;
  logic was_strobe = 1'b0;
  int   ph;
  int   s0, s1, idx;
  logic [3:0] obs [4];

  function automatic string kname(input int k);
    case (k)
      0: return "press";
      1: return "release";
      2: return "long";
      default: return "repeat";
    endcase
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    sample_en = 1'b0;
    ph = 0;
    forever begin
      @(negedge clk);
      ph = (ph == 4) ? 0 : ph + 1;
      sample_en = (ph == 4);
    end
  end

  always @(posedge clk) begin
    was_strobe <= sample_en;
    if (sample_en) scnt <= scnt + 1;
  end

  always @(negedge clk) begin
    obs[0] = key_press;
    obs[1] = key_release;
    obs[2] = key_long;
    obs[3] = key_repeat;
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        for (int c = 0; c < 4; c++) begin
          if (obs[k][c]) begin
            idx = -1;
            if (was_strobe) begin
              foreach (sb[i]) begin
                if (idx < 0 && sb[i].s == scnt &&
                    sb[i].ch == c && sb[i].kind == k)
                  idx = i;
              end
            end
            checks++;
            if (idx >= 0) sb.delete(idx);
            else begin
              errors++;
              $display("FAIL unexpected %s[%0d] at strobe %0d: got 1 want 0",
                       kname(k), c, scnt);
            end
          end
        end
      end
      if (was_strobe) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].s <= scnt) begin
            checks++;
            errors++;
            $display("FAIL missed %s[%0d] at strobe %0d: got 0 want 1",
                     kname(sb[i].kind), sb[i].ch, sb[i].s);
            sb.delete(i);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic push(input int s, input int ch, input int kind);
    ev_t e;
    e.s = s;
    e.ch = ch;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int s);
    while (scnt < s) @(negedge clk);
    #2;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, " level"}, 32'(key_level), 32'h0);
    chk({nm, " pulses"},
        32'({key_press, key_release, key_long, key_repeat}), 32'h0);
  endtask

  initial begin
    tbl[0] = '{4'b1110, 4, 4'b0001, 4'b0000, 4'b0001};
    tbl[1] = '{4'b1110, 5, 4'b0000, 4'b0000, 4'b0001};
    tbl[2] = '{4'b1111, 4, 4'b0000, 4'b0001, 4'b0000};
    tbl[3] = '{4'b1101, 3, 4'b0000, 4'b0000, 4'b0000};
    tbl[4] = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b0000};
    tbl[5] = '{4'b1101, 4, 4'b0010, 4'b0000, 4'b0010};
    tbl[6] = '{4'b1111, 4, 4'b0000, 4'b0010, 4'b0000};
    tbl[7] = '{4'b0110, 4, 4'b1001, 4'b0000, 4'b1001};
    tbl[8] = '{4'b1111, 4, 4'b0000, 4'b1001, 4'b0000};

    rst_n = 1'b0;
    key_raw = 4'hF;
    repeat (3) @(negedge clk);
    #2;
    chk_quiet("reset");
    rst_n = 1'b1;
    wait_to(scnt + 1);

    foreach (tbl[i]) begin
      s0 = scnt;
      key_raw = tbl[i].raw;
      for (int c = 0; c < 4; c++) begin
        if (tbl[i].press[c]) push(s0 + tbl[i].n, c, 0);
        if (tbl[i].rel[c])   push(s0 + tbl[i].n, c, 1);
      end
      wait_to(s0 + tbl[i].n);
      chk($sformatf("row%0d level", i), 32'(key_level), 32'(tbl[i].lvl));
    end

    s0 = scnt;
    key_raw = 4'b1011;
    push(s0 + 4, 2, 0);
    push(s0 + 14, 2, 2);
    for (int r = 17; r <= 26; r += 3) push(s0 + r, 2, 3);
    wait_to(s0 + 26);
    chk("long level", 32'(key_level), 32'h4);
    key_raw = 4'hF;
    push(s0 + 30, 2, 1);
    wait_to(s0 + 30);
    chk("long rel level", 32'(key_level), 32'h0);

    s0 = scnt;
    key_raw = 4'b1110;
    push(s0 + 4, 0, 0);
    wait_to(s0 + 8);
    key_raw = 4'hF;
    wait_to(s0 + 10);
    chk("glitch level", 32'(key_level), 32'h1);
    key_raw = 4'b1110;
    push(s0 + 17, 0, 2);
    wait_to(s0 + 17);
    chk("glitch long level", 32'(key_level), 32'h1);
    key_raw = 4'hF;
    push(s0 + 21, 0, 1);
    wait_to(s0 + 21);
    chk("glitch rel level", 32'(key_level), 32'h0);

    s0 = scnt;
    key_raw = 4'b1011;
    push(s0 + 4, 2, 0);
    push(s0 + 14, 2, 2);
    wait_to(s0 + 16);
    chk("pre-reset level", 32'(key_level), 32'h4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_quiet("async reset");
    repeat (7) @(negedge clk);
    s1 = scnt;
    wait_to(s1 + 1);
    rst_n = 1'b1;
    push(s1 + 5, 2, 0);
    wait_to(s1 + 4);
    chk("re-deb level", 32'(key_level), 32'h0);
    wait_to(s1 + 5);
    chk("re-press level", 32'(key_level), 32'h4);
    key_raw = 4'hF;
    push(s1 + 9, 2, 1);
    wait_to(s1 + 9);
    chk("final level", 32'(key_level), 32'h0);

    wait_to(scnt + 2);
    chk("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
